// File: rtl/ps_kernel_ctrl.sv
// ---------------------------------------------------------------------------
// ps_kernel_ctrl
//   Line-buffer controller feeding a 3x3 kernel stage. Incoming pixels are
//   written round-robin into four line banks of LINE_LENGTH pixels. Once three
//   complete lines are stored, the three oldest banks are read in parallel,
//   one column per cycle, and assembled into 3x3 windows.
//
//   Optional feature macro: PS_KCTRL_EDGE_PAD_EN
//     undefined : LINE_LENGTH-2 windows per line, no edge replication
//     defined   : LINE_LENGTH windows per line, first/last column replicated
//
// Ports
//   i_clk       single clock, rising edge
//   i_rst       synchronous active-high reset
//   i_valid     input pixel valid
//   i_data      input pixel
//   o_ready     pixel accepted when i_valid && o_ready
//   o_valid     o_window valid
//   o_window    {r0c0,r0c1,r0c2,r1c0..r2c2}, r0 = oldest line, r0c0 in MSBs
//   o_eol       marks the last window of a line
//   i_ready     downstream accepts a window when o_valid && i_ready
//   o_overflow  sticky flag: a pixel arrived while o_ready was low
// ---------------------------------------------------------------------------
module ps_kernel_ctrl #(
  parameter int LINE_LENGTH = 640,
  parameter int DATA_W      = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [DATA_W-1:0]   i_data,
  output logic                o_ready,
  output logic                o_valid,
  output logic [9*DATA_W-1:0] o_window,
  output logic                o_eol,
  input  logic                i_ready,
  output logic                o_overflow
);

  localparam int WR_W = $clog2(LINE_LENGTH);
  localparam int RD_W = $clog2(LINE_LENGTH + 1);
`ifdef PS_KCTRL_EDGE_PAD_EN
  // One extra read beat after the last column; it re-presents that column
  // as the right-hand neighbour of the final window.
  localparam int RD_LAST_I  = LINE_LENGTH;
  localparam int FIRST_WIN_I = 1;
`else
  localparam int RD_LAST_I  = LINE_LENGTH - 1;
  localparam int FIRST_WIN_I = 2;
`endif
  localparam logic [WR_W-1:0] WR_LAST      = WR_W'(LINE_LENGTH - 1);
  localparam logic [RD_W-1:0] RD_LAST      = RD_W'(RD_LAST_I);
  localparam logic [RD_W-1:0] RD_FIRST_WIN = RD_W'(FIRST_WIN_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0]        r_mem [0:3][0:LINE_LENGTH-1];
  logic [1:0]               r_wr_sel;
  logic [WR_W-1:0]          r_wr_col;
  logic [1:0]               r_rd_sel;
  logic [RD_W-1:0]          r_rd_col;
  logic [2:0]               r_lines_full;
  logic                     r_ready;
  logic                     r_overflow;
  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [2:0]               w_lines_full_nxt;
  logic [2:0][DATA_W-1:0]   r_q;   // RAM output column, index = row
  logic [2:0][DATA_W-1:0]   r_c0;  // oldest column of the window
  logic [2:0][DATA_W-1:0]   r_c1;  // middle column of the window
  logic                     r_q_vld;
  logic                     r_q_first;
  logic                     r_out_vld;
  logic                     r_out_eol;

  logic                     w_wr_fire;
  logic                     w_line_done;
  logic                     w_adv;
  logic                     w_issue;
  logic                     w_rd_pix;
  logic                     w_release;
  logic [1:0]               w_bank1;
  logic [1:0]               w_bank2;
  logic [WR_W-1:0]          w_rd_addr;

  assign w_wr_fire   = i_valid && r_ready;
  assign w_line_done = w_wr_fire && (r_wr_col == WR_LAST);
  // The whole read pipeline moves only when the presented window is taken.
  assign w_adv       = !r_out_vld || i_ready;
  assign w_issue     = (r_state == ST_READ) && w_adv;
`ifdef PS_KCTRL_EDGE_PAD_EN
  assign w_rd_pix    = w_issue && (r_rd_col != RD_LAST);
`else
  assign w_rd_pix    = w_issue;
`endif
  assign w_release   = (r_state == ST_DONE) && r_out_vld && r_out_eol && i_ready;
  assign w_bank1     = r_rd_sel + 2'd1;
  assign w_bank2     = r_rd_sel + 2'd2;
  assign w_rd_addr   = r_rd_col[WR_W-1:0];

  assign o_ready    = r_ready;
  assign o_overflow = r_overflow;
  assign o_valid    = r_out_vld;
  assign o_eol      = r_out_eol;
  assign o_window   = {r_c0[0], r_c1[0], r_q[0],
                       r_c0[1], r_c1[1], r_q[1],
                       r_c0[2], r_c1[2], r_q[2]};

  // Line bank storage: write port only, contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_sel][r_wr_col] <= i_data;
    end
  end

  // Stored-line counter: saturating, simultaneous fill and release cancel.
  always_comb begin
    w_lines_full_nxt = r_lines_full;
    if (w_line_done && !w_release) begin
      if (r_lines_full != 3'd4) begin
        w_lines_full_nxt = r_lines_full + 3'd1;
      end else begin
        w_lines_full_nxt = r_lines_full;
      end
    end else if (w_release && !w_line_done) begin
      if (r_lines_full != 3'd0) begin
        w_lines_full_nxt = r_lines_full - 3'd1;
      end else begin
        w_lines_full_nxt = r_lines_full;
      end
    end else begin
      w_lines_full_nxt = r_lines_full;
    end
  end

  // Write pointer, line counter, back-pressure and overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_sel     <= 2'd0;
      r_wr_col     <= {WR_W{1'b0}};
      r_lines_full <= 3'd0;
      r_ready      <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        if (r_wr_col == WR_LAST) begin
          r_wr_col <= {WR_W{1'b0}};
          r_wr_sel <= r_wr_sel + 2'd1;
        end else begin
          r_wr_col <= r_wr_col + {{(WR_W-1){1'b0}}, 1'b1};
        end
      end
      r_lines_full <= w_lines_full_nxt;
      // Looking at the next count drops ready in the same cycle the fourth
      // line lands, so the bank under the reader is never overwritten.
      r_ready      <= (w_lines_full_nxt != 3'd4);
      if (i_valid && !r_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Read FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_lines_full >= 3'd3) w_state_nxt = ST_READ;
        else                      w_state_nxt = ST_IDLE;
      end
      ST_READ: begin
        if (w_issue && (r_rd_col == RD_LAST)) w_state_nxt = ST_DONE;
        else                                   w_state_nxt = ST_READ;
      end
      ST_DONE: begin
        if (w_release) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read FSM state, read column and read bank pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_rd_col <= {RD_W{1'b0}};
      r_rd_sel <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        if (r_rd_col == RD_LAST) r_rd_col <= {RD_W{1'b0}};
        else                     r_rd_col <= r_rd_col + {{(RD_W-1){1'b0}}, 1'b1};
      end
      if (w_release) begin
        r_rd_sel <= r_rd_sel + 2'd1;
      end
    end
  end

  // Read pipeline: RAM output column, window shift register, output tags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q       <= {(3*DATA_W){1'b0}};
      r_c0      <= {(3*DATA_W){1'b0}};
      r_c1      <= {(3*DATA_W){1'b0}};
      r_q_vld   <= 1'b0;
      r_q_first <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_eol <= 1'b0;
    end else if (w_adv) begin
      // The pad beat leaves r_q untouched so the last column repeats.
      if (w_rd_pix) begin
        r_q <= {r_mem[w_bank2][w_rd_addr],
                r_mem[w_bank1][w_rd_addr],
                r_mem[r_rd_sel][w_rd_addr]};
      end
      r_q_vld   <= w_issue;
      r_q_first <= w_issue && (r_rd_col == {RD_W{1'b0}});
      r_out_vld <= w_issue && (r_rd_col >= RD_FIRST_WIN);
      r_out_eol <= w_issue && (r_rd_col == RD_LAST);
      if (r_q_vld) begin
        r_c1 <= r_q;
`ifdef PS_KCTRL_EDGE_PAD_EN
        // Column 0 fills both older slots: it is its own left neighbour.
        if (r_q_first) r_c0 <= r_q;
        else           r_c0 <= r_c1;
`else
        r_c0 <= r_c1;
`endif
      end
    end
  end

endmodule
